// File: rtl/ds_fifo_pkt_if.sv
// ds_if: valid/ready data-stream bundle shared by producers and consumers.
// Latency: none, wires only.
// Backpressure: a beat moves when vld and rdy are both high in the same cycle.
interface ds_if #(
    parameter type DTYPE = logic [7:0]
) ();
    DTYPE data;
    logic vld;
    logic rdy;

    modport mst (output data, output vld, input rdy);
    modport slv (input data, input vld, output rdy);
endinterface

// File: rtl/ds_fifo_pkt.sv
// ds_fifo_pkt: packet-aware FIFO with FWFT read; store-and-forward (rollback on drop/oversize) or stream mode.
// Latency: a committed word is presented on if_rd one cycle after the write that commits it.
// Backpressure: if_wr.rdy is registered, low while buffered+open words fill storage, forced high while discarding.
module ds_fifo_pkt #(
    parameter int   CAPACITY = 16,
    parameter type  DTYPE    = logic [7:0],
    parameter logic PKT_MODE = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    ds_if.slv                             if_wr,
    input  logic                          i_wr_last,
    input  logic                          i_wr_drop,
    ds_if.mst                             if_rd,
    output logic                          o_rd_last,
    output logic [$clog2(CAPACITY+1)-1:0] o_wc,
    output logic [$clog2(CAPACITY+1)-1:0] o_pkts,
    output logic                          o_drop,
    output logic                          o_ovf
);
    localparam int PW = $clog2(CAPACITY);
    localparam int CW = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] CAP_C   = CW'(CAPACITY);
    localparam logic [PW-1:0] PTR_MAX = PW'(CAPACITY - 1);

    typedef struct packed {
        logic last;
        DTYPE data;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DISCARD} state_t;

    ent_t          mem [CAPACITY];
    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, cmt_ptr_q, cmt_ptr_d, spec_ptr_q, spec_ptr_d;
    logic [CW-1:0] spec_cnt_q, spec_cnt_d, wc_q, wc_d, pkts_q, pkts_d;
    logic [CW-1:0] wc_rd, spec_rd;
    logic          wr_rdy_q, wr_rdy_d, rd_vld_q, rd_vld_d;
    logic          drop_q, drop_d, ovf_q, ovf_d;
    logic          wr_xfer, rd_xfer, store, commit, pkt_end, drop_rb, ovf_rb;
    ent_t          rd_ent;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    assign wr_xfer    = if_wr.vld & wr_rdy_q;
    assign rd_xfer    = rd_vld_q & if_rd.rdy;
    assign rd_ent     = mem[rd_ptr_q];

    assign if_wr.rdy  = wr_rdy_q;
    assign if_rd.vld  = rd_vld_q;
    assign if_rd.data = rd_vld_q ? rd_ent.data : DTYPE'('0);
    assign o_rd_last  = rd_vld_q & rd_ent.last;
    assign o_wc       = wc_q;
    assign o_pkts     = pkts_q;
    assign o_drop     = drop_q;
    assign o_ovf      = ovf_q;

    // Next-state: pointers, counts, rollback decisions and the packet FSM.
    always_comb begin
        // counts as they stand after this cycle's read, before any write effect
        wc_rd   = wc_q - CW'(rd_xfer);
        spec_rd = spec_cnt_q - CW'(rd_xfer);

        // drop beats are never stored in packet mode; stream mode ignores drop
        store   = wr_xfer && (state_q != S_DISCARD) && (!i_wr_drop || !PKT_MODE);
        commit  = store && (i_wr_last || !PKT_MODE);
        pkt_end = store && i_wr_last;
        drop_rb = PKT_MODE && wr_xfer && i_wr_drop && (state_q != S_DISCARD);
        // an open packet that fills storage with nothing readable can never complete
        ovf_rb  = PKT_MODE && store && !i_wr_last && ((spec_rd + CW'(1)) == CAP_C) && (wc_rd == '0);

        rd_ptr_d   = rd_xfer ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        spec_ptr_d = spec_ptr_q;
        wc_d       = wc_rd;
        spec_cnt_d = spec_rd;
        pkts_d     = pkts_q - CW'(rd_xfer && rd_ent.last) + CW'(pkt_end);

        if (drop_rb || ovf_rb) begin
            spec_ptr_d = cmt_ptr_q;
            spec_cnt_d = wc_rd;
        end else if (store) begin
            spec_ptr_d = ptr_inc(spec_ptr_q);
            spec_cnt_d = spec_rd + CW'(1);
            if (commit) begin
                // the whole open packet, including this beat, becomes readable
                cmt_ptr_d = ptr_inc(spec_ptr_q);
                wc_d      = spec_rd + CW'(1);
            end
        end

        state_d = state_q;
        if (PKT_MODE && wr_xfer) begin
            case (state_q)
                S_IDLE: begin
                    if (!i_wr_last) state_d = (i_wr_drop || ovf_rb) ? S_DISCARD : S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (i_wr_last)                 state_d = S_IDLE;
                    else if (i_wr_drop || ovf_rb)  state_d = S_DISCARD;
                end
                default: begin
                    if (i_wr_last) state_d = S_IDLE;
                end
            endcase
        end

        wr_rdy_d = (state_d == S_DISCARD) || (spec_cnt_d < CAP_C);
        rd_vld_d = (wc_d != '0);
        drop_d   = drop_rb;
        ovf_d    = ovf_rb;
    end

    // Control state registers; storage itself is not reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            spec_ptr_q <= '0;
            spec_cnt_q <= '0;
            wc_q       <= '0;
            pkts_q     <= '0;
            wr_rdy_q   <= 1'b1;
            rd_vld_q   <= 1'b0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            spec_ptr_q <= spec_ptr_d;
            spec_cnt_q <= spec_cnt_d;
            wc_q       <= wc_d;
            pkts_q     <= pkts_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_vld_q   <= rd_vld_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
        end
    end

    // Write accepted beats at the speculative pointer.
    always_ff @(posedge i_clk) begin
        if (store) mem[spec_ptr_q] <= ent_t'{last: i_wr_last, data: if_wr.data};
    end
endmodule

// File: tb/tb_ds_fifo_pkt.sv
// tb_ds_fifo_pkt: scoreboard bench for a packet-mode (CAPACITY 8) and a stream-mode (CAPACITY 5) instance.
// Latency: model predicts every registered output one cycle after the inputs that cause it.
// Backpressure: drivers hold a beat until rdy is seen; read ready follows a per-instance mode.
module tb_ds_fifo_pkt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2];
    logic       wr_vld  [2];
    logic       wr_last [2];
    logic       wr_drop [2];
    logic       rd_rdy  [2];
    logic [7:0] wr_dat  [2];
    int         rd_mode [2];

    logic       s_wr_rdy  [2];
    logic       s_rd_vld  [2];
    logic       s_rd_last [2];
    logic       s_drop    [2];
    logic       s_ovf     [2];
    logic [7:0] s_rd_dat  [2];
    int         s_wc      [2];
    int         s_pkts    [2];

    logic [3:0] wc0, pkts0;
    logic [2:0] wc1, pkts1;

    ds_if #(.DTYPE(logic [7:0])) wr0 ();
    ds_if #(.DTYPE(logic [7:0])) rd0 ();
    ds_if #(.DTYPE(logic [7:0])) wr1 ();
    ds_if #(.DTYPE(logic [7:0])) rd1 ();

    assign wr0.vld  = wr_vld[0];
    assign wr0.data = wr_dat[0];
    assign rd0.rdy  = rd_rdy[0];
    assign wr1.vld  = wr_vld[1];
    assign wr1.data = wr_dat[1];
    assign rd1.rdy  = rd_rdy[1];

    assign s_wr_rdy[0] = wr0.rdy;
    assign s_rd_vld[0] = rd0.vld;
    assign s_rd_dat[0] = rd0.data;
    assign s_wc[0]     = int'(wc0);
    assign s_pkts[0]   = int'(pkts0);
    assign s_wr_rdy[1] = wr1.rdy;
    assign s_rd_vld[1] = rd1.vld;
    assign s_rd_dat[1] = rd1.data;
    assign s_wc[1]     = int'(wc1);
    assign s_pkts[1]   = int'(pkts1);

    ds_fifo_pkt #(.CAPACITY(8), .DTYPE(logic [7:0]), .PKT_MODE(1'b1)) u_pkt (
        .i_clk     (clk),
        .i_rst_n   (rst_n[0]),
        .if_wr     (wr0),
        .i_wr_last (wr_last[0]),
        .i_wr_drop (wr_drop[0]),
        .if_rd     (rd0),
        .o_rd_last (s_rd_last[0]),
        .o_wc      (wc0),
        .o_pkts    (pkts0),
        .o_drop    (s_drop[0]),
        .o_ovf     (s_ovf[0])
    );

    ds_fifo_pkt #(.CAPACITY(5), .DTYPE(logic [7:0]), .PKT_MODE(1'b0)) u_str (
        .i_clk     (clk),
        .i_rst_n   (rst_n[1]),
        .if_wr     (wr1),
        .i_wr_last (wr_last[1]),
        .i_wr_drop (wr_drop[1]),
        .if_rd     (rd1),
        .o_rd_last (s_rd_last[1]),
        .o_wc      (wc1),
        .o_pkts    (pkts1),
        .o_drop    (s_drop[1]),
        .o_ovf     (s_ovf[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: readable words, the open packet, and the expected read stream.
    logic [8:0] mdl_q  [2][$];
    logic [8:0] open_q [2][$];
    logic [8:0] exp_q  [2][$];
    bit         disc     [2];
    bit         exp_drop [2];
    bit         exp_ovf  [2];

    function automatic int cap_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic bit pmode_of(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        mdl_q[k]    = {};
        open_q[k]   = {};
        exp_q[k]    = {};
        disc[k]     = 1'b0;
        exp_drop[k] = 1'b0;
        exp_ovf[k]  = 1'b0;
    endtask

    task automatic model_write(input int k);
        logic [8:0] w;
        w = {wr_last[k], wr_dat[k]};
        if (!pmode_of(k)) begin
            mdl_q[k].push_back(w);
            exp_q[k].push_back(w);
        end else if (disc[k]) begin
            if (wr_last[k]) disc[k] = 1'b0;
        end else if (wr_drop[k]) begin
            open_q[k]   = {};
            exp_drop[k] = 1'b1;
            disc[k]     = !wr_last[k];
        end else begin
            open_q[k].push_back(w);
            if (wr_last[k]) begin
                for (int i = 0; i < open_q[k].size(); i++) begin
                    mdl_q[k].push_back(open_q[k][i]);
                    exp_q[k].push_back(open_q[k][i]);
                end
                open_q[k] = {};
            end else if (open_q[k].size() == cap_of(k) && mdl_q[k].size() == 0) begin
                open_q[k]  = {};
                exp_ovf[k] = 1'b1;
                disc[k]    = 1'b1;
            end
        end
    endtask

    // Model: check status outputs, then apply this cycle's read and write.
    initial begin : model
        int occ;
        int npk;
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n[k]) begin
                    model_reset(k);
                    continue;
                end
                occ = mdl_q[k].size();
                npk = 0;
                for (int i = 0; i < occ; i++) if (mdl_q[k][i][8]) npk++;
                chk("wr_rdy", k, int'(s_wr_rdy[k]), int'(disc[k] || (occ + open_q[k].size() < cap_of(k))));
                chk("rd_vld", k, int'(s_rd_vld[k]), int'(occ != 0));
                chk("wc",     k, s_wc[k], occ);
                chk("pkts",   k, s_pkts[k], npk);
                chk("drop",   k, int'(s_drop[k]), int'(exp_drop[k]));
                chk("ovf",    k, int'(s_ovf[k]), int'(exp_ovf[k]));
                exp_drop[k] = 1'b0;
                exp_ovf[k]  = 1'b0;
                if (s_rd_vld[k] && rd_rdy[k] && occ > 0) void'(mdl_q[k].pop_front());
                if (wr_vld[k] && s_wr_rdy[k]) model_write(k);
            end
        end
    end

    // Monitor: every read handshake pops the scoreboard and compares the word.
    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n[k] && s_rd_vld[k] && rd_rdy[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected dut%0d got data %0h want none at %0t", k, s_rd_dat[k], $time);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk("rd_dat",  k, int'(s_rd_dat[k]), int'(e[7:0]));
                        chk("rd_last", k, int'(s_rd_last[k]), int'(e[8]));
                    end
                end
            end
        end
    end

    // Read-ready generator: 0 always ready, 1 random, 2 blocked.
    initial begin : rd_gen
        rd_rdy[0] = 1'b0;
        rd_rdy[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                case (rd_mode[k])
                    0:       rd_rdy[k] = 1'b1;
                    1:       rd_rdy[k] = ($urandom_range(0, 99) < 70);
                    default: rd_rdy[k] = 1'b0;
                endcase
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic l, input logic dr);
        bit acc;
        bit done;
        done       = 1'b0;
        wr_vld[k]  = 1'b1;
        wr_dat[k]  = d;
        wr_last[k] = l;
        wr_drop[k] = dr;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            acc = s_wr_rdy[k];
            @(posedge clk);
            #1;
            done = acc;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout dut%0d got no rdy want rdy within 200 cycles at %0t", k, $time);
        end
        wr_vld[k]  = 1'b0;
        wr_last[k] = 1'b0;
        wr_drop[k] = 1'b0;
    endtask

    task automatic rand_traffic(input int k, input int npkt, input int maxlen);
        int len;
        int dpos;
        for (int p = 0; p < npkt; p++) begin
            len  = $urandom_range(1, maxlen);
            dpos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int b = 0; b < len; b++) begin
                send(k, 8'($urandom), (b == len - 1), (b == dpos));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
    endtask

    initial begin : stim
        for (int k = 0; k < 2; k++) begin
            rst_n[k]   = 1'b0;
            wr_vld[k]  = 1'b0;
            wr_last[k] = 1'b0;
            wr_drop[k] = 1'b0;
            wr_dat[k]  = 8'h00;
            rd_mode[k] = 0;
        end
        idle(3);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(2);

        // store-and-forward: nothing visible until the last beat
        send(0, 8'h11, 1'b0, 1'b0);
        send(0, 8'h22, 1'b0, 1'b0);
        send(0, 8'h33, 1'b1, 1'b0);
        idle(5);
        // drop on the last beat, then a single-beat packet
        send(0, 8'hA0, 1'b0, 1'b0);
        send(0, 8'hA1, 1'b0, 1'b0);
        send(0, 8'hA2, 1'b1, 1'b1);
        idle(2);
        send(0, 8'hB0, 1'b1, 1'b0);
        idle(3);
        // drop on beat 2 of 5: remaining beats swallowed
        send(0, 8'hC0, 1'b0, 1'b0);
        send(0, 8'hC1, 1'b0, 1'b1);
        send(0, 8'hC2, 1'b0, 1'b0);
        send(0, 8'hC3, 1'b0, 1'b0);
        send(0, 8'hC4, 1'b1, 1'b0);
        idle(3);
        // oversize: 10 beats into an empty 8-word FIFO
        for (int b = 0; b < 10; b++) send(0, 8'(8'hD0 + b), (b == 9), 1'b0);
        idle(3);
        // fill with two packets while reads are blocked, then read during the third
        rd_mode[0] = 2;
        idle(2);
        for (int b = 0; b < 6; b++) send(0, 8'(8'hE0 + b), (b % 3 == 2), 1'b0);
        fork
            for (int b = 0; b < 3; b++) send(0, 8'(8'hF0 + b), (b == 2), 1'b0);
            begin
                idle(8);
                rd_mode[0] = 0;
            end
        join
        idle(12);

        // stream mode: single word visible the next cycle
        send(1, 8'h5A, 1'b1, 1'b0);
        idle(3);
        // fill to full mid-packet, then reset asynchronously
        rd_mode[1] = 2;
        idle(2);
        for (int b = 0; b < 5; b++) send(1, 8'(8'h60 + b), 1'b0, 1'b0);
        idle(1);
        rst_n[1] = 1'b0;
        #1;
        chk("rst_wr_rdy",  1, int'(s_wr_rdy[1]), 1);
        chk("rst_rd_vld",  1, int'(s_rd_vld[1]), 0);
        chk("rst_rd_last", 1, int'(s_rd_last[1]), 0);
        chk("rst_wc",      1, s_wc[1], 0);
        chk("rst_pkts",    1, s_pkts[1], 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n[1]   = 1'b1;
        rd_mode[1] = 0;
        idle(2);

        // randomized traffic on both instances
        rd_mode[0] = 1;
        rd_mode[1] = 1;
        fork
            rand_traffic(0, 40, 10);
            rand_traffic(1, 40, 4);
        join
        rd_mode[0] = 0;
        rd_mode[1] = 0;
        idle(30);
        chk("drained", 0, exp_q[0].size(), 0);
        chk("drained", 1, exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
